// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA frame-buffer arbiter.
// Resolution, RGB565 colour type, arbiter FSM state and colour constants.
package vga_fb_pkg;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;

  localparam int ADDR_W_DEF = 14;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t BLACK = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } fb_state_e;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Combinational window hit, read address and write-range check
// for the frame-buffer arbiter.
module vga_fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int IMG_X0 = 270,
  parameter int IMG_Y0 = 190,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              pix_req,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              hit,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_in_range
);

  localparam logic [31:0] X0   = 32'(IMG_X0);
  localparam logic [31:0] X1   = 32'(IMG_X0 + IMG_W - 1);
  localparam logic [31:0] Y0   = 32'(IMG_Y0);
  localparam logic [31:0] Y1   = 32'(IMG_Y0 + IMG_H - 1);
  localparam logic [31:0] W    = 32'(IMG_W);
  localparam logic [31:0] NPIX = 32'(IMG_W * IMG_H);

  logic [31:0] px;
  logic [31:0] py;
  logic [31:0] x_off;
  logic [31:0] y_off;
  logic        in_x;
  logic        in_y;

  assign px    = 32'(pix_x);
  assign py    = 32'(pix_y);
  assign x_off = px - X0;
  assign y_off = py - Y0;

  assign in_x = (px >= X0) && (px <= X1);
  assign in_y = (py >= Y0) && (py <= Y1);
  assign hit  = pix_req && in_x && in_y;

  // Full-width product, then truncated to the RAM address width
  assign rd_addr = ADDR_W'(y_off * W + x_off);

  assign wr_in_range = 32'(wr_addr) < NPIX;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: VGA reads win, writes fill free cycles.
// Define FB_FRAME_LOCK_EN to grant writes only during v_blank.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int      IMG_W     = 100,
  parameter int      IMG_H     = 100,
  parameter int      IMG_X0    = 270,
  parameter int      IMG_Y0    = 190,
  parameter int      ADDR_W    = ADDR_W_DEF,
  parameter rgb565_t BG_COLOUR = WHITE
) (
  input  logic              Clk_int,
  input  logic              Sys_Rst_n,
  input  logic              pix_req,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              v_blank,
  output rgb565_t           pix_colour,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  rgb565_t           wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output rgb565_t           ram_wr_data,
  input  rgb565_t           ram_rd_data,
  output logic              err_addr
);

  fb_state_e         state;
  fb_state_e         state_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              wen_nx;
  rgb565_t           wdata_nx;
  logic              err_nx;

  logic              hit;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_in_range;
  logic              wr_ok;
  logic              wr_go;

  logic hit_d1;
  logic hit_d2;
  logic req_d1;
  logic req_d2;

  vga_fb_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .IMG_X0 (IMG_X0),
    .IMG_Y0 (IMG_Y0),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .wr_addr     (wr_addr),
    .hit         (hit),
    .rd_addr     (rd_addr),
    .wr_in_range (wr_in_range)
  );

`ifdef FB_FRAME_LOCK_EN
  assign wr_ok = v_blank;
`else
  logic unused_v_blank;
  assign unused_v_blank = v_blank;
  assign wr_ok = 1'b1;
`endif

  // The grant cycle is the S_WR cycle; a held request is ignored then
  assign wr_gnt = (state == S_WR);
  assign wr_go  = !hit && wr_req && !wr_gnt && wr_ok;

  always_comb begin
    state_nx = S_IDLE;
    addr_nx  = ram_addr;
    wen_nx   = 1'b0;
    wdata_nx = ram_wr_data;
    err_nx   = err_addr;
    unique case (1'b1)
      hit: begin
        state_nx = S_RD;
        addr_nx  = rd_addr;
      end
      wr_go: begin
        state_nx = S_WR;
        addr_nx  = wr_addr;
        wdata_nx = wr_data;
        wen_nx   = wr_in_range;
        err_nx   = err_addr | !wr_in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      state       <= S_IDLE;
      ram_addr    <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_data <= '0;
      err_addr    <= 1'b0;
    end else begin
      state       <= state_nx;
      ram_addr    <= addr_nx;
      ram_wr_en   <= wen_nx;
      ram_wr_data <= wdata_nx;
      err_addr    <= err_nx;
    end
  end

  // Read pipeline: address at t+1, RAM data at t+2, colour at t+3
  always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      hit_d1     <= 1'b0;
      hit_d2     <= 1'b0;
      req_d1     <= 1'b0;
      req_d2     <= 1'b0;
      pix_colour <= BLACK;
    end else begin
      hit_d1 <= hit;
      hit_d2 <= hit_d1;
      req_d1 <= pix_req;
      req_d2 <= req_d1;
      if (hit_d2) begin
        pix_colour <= ram_rd_data;
      end else if (req_d2) begin
        pix_colour <= BG_COLOUR;
      end else begin
        pix_colour <= BLACK;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: image-level reference model,
// per-cycle compare, and directed vectors with literal expectations.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int W  = 100;
  localparam int H  = 100;
  localparam int X0 = 270;
  localparam int Y0 = 190;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_req = 1'b0;
  logic [9:0]    pix_x = '0;
  logic [9:0]    pix_y = '0;
  logic          v_blank = 1'b0;
  logic [15:0]   pix_colour;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          wr_gnt;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_en;
  logic [15:0]   ram_wr_data;
  logic [15:0]   ram_rd_data;
  logic          err_addr;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_fb_arbiter dut (
    .Clk_int     (clk),
    .Sys_Rst_n   (rst_n),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .v_blank     (v_blank),
    .pix_colour  (pix_colour),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data),
    .err_addr    (err_addr)
  );

  logic [15:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_addr];
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: image contents plus spec-level arbitration rules
  logic [15:0]   ref_img [0:(1<<AW)-1];
  logic          e_gnt;
  logic          e_wen;
  logic          e_err;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wdata;
  logic [15:0]   c1, c2, c3;
  bit            m_hit;
  bit            m_ok;
  int            m_x, m_y, m_ra;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt = 0; e_wen = 0; e_err = 0;
      e_addr = '0; e_wdata = '0;
      c1 = '0; c2 = '0; c3 = '0;
      for (int i = 0; i < (1 << AW); i++) ref_img[i] = '0;
    end else begin
      m_x = int'(pix_x);
      m_y = int'(pix_y);
      m_hit = pix_req && m_x >= X0 && m_x < X0 + W &&
              m_y >= Y0 && m_y < Y0 + H;
      m_ra = (m_y - Y0) * W + (m_x - X0);
`ifdef FB_FRAME_LOCK_EN
      m_ok = v_blank;
`else
      m_ok = 1;
`endif
      c3 = c2;
      c2 = c1;
      c1 = m_hit ? ref_img[m_ra] : (pix_req ? 16'hFFFF : 16'h0000);
      if (m_hit) begin
        e_addr = AW'(m_ra);
        e_wen = 0;
        e_gnt = 0;
      end else if (wr_req && !e_gnt && m_ok) begin
        e_gnt = 1;
        e_addr = wr_addr;
        e_wdata = wr_data;
        if (int'(wr_addr) < W * H) begin
          e_wen = 1;
          ref_img[wr_addr] = wr_data;
        end else begin
          e_wen = 0;
          e_err = 1;
        end
      end else begin
        e_gnt = 0;
        e_wen = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_pix_colour", pix_colour, c3);
      chk("m_wr_gnt", wr_gnt, e_gnt);
      chk("m_ram_wr_en", ram_wr_en, e_wen);
      chk("m_ram_addr", ram_addr, e_addr);
      chk("m_ram_wr_data", ram_wr_data, e_wdata);
      chk("m_err_addr", err_addr, e_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d,
                          output int lat, output logic wen_at,
                          output logic [AW-1:0] addr_at);
    step();
    wr_req = 1; wr_addr = a; wr_data = d;
    lat = 0;
    wen_at = 0; addr_at = '0;
    forever begin
      @(negedge clk);
      if (wr_gnt) begin
        wen_at = ram_wr_en;
        addr_at = ram_addr;
        break;
      end
      lat++;
      if (lat > 60) begin
        checks++; errors++;
        $display("FAIL wr_timeout act=nogrant exp=grant addr=%0d", a);
        break;
      end
    end
    step();
    wr_req = 0;
  endtask

  task automatic read_px(input int x, input int y, input bit req,
                         input logic [15:0] exp, input string n);
    step();
    pix_x = 10'(x); pix_y = 10'(y); pix_req = req;
    step();
    pix_req = 0;
    step();
    step();
    @(negedge clk);
    chk(n, pix_colour, exp);
  endtask

  int            lat;
  logic          wen_at;
  logic [AW-1:0] addr_at;

  initial begin
`ifdef FB_FRAME_LOCK_EN
    v_blank = 1;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_outputs",
          {pix_colour, 1'b0, wr_gnt, ram_wr_en, err_addr}, 32'h0);
      chk("rst_ram", {ram_addr, ram_wr_data}, 32'h0);
      chk("rst_state", dut.state, S_IDLE);
    end

    do_write(14'd0, 16'hF800, lat, wen_at, addr_at);
    chk("wr0_latency", lat, 1);
    chk("wr0_wen", wen_at, 1);
    chk("wr0_addr", addr_at, 0);
    read_px(270, 190, 1, 16'hF800, "rd_270_190");

    read_px(269, 190, 1, 16'hFFFF, "rd_left_out");
    read_px(370, 190, 1, 16'hFFFF, "rd_right_out");
    read_px(270, 290, 1, 16'hFFFF, "rd_below_out");
    read_px(300, 200, 0, 16'h0000, "no_req_black");

    do_write(14'd9999, 16'h1234, lat, wen_at, addr_at);
    read_px(369, 289, 1, 16'h1234, "rd_last_px");

    // Read contention: the write must wait for a non-hit cycle
    step();
    pix_x = 10'd300; pix_y = 10'd200; pix_req = 1;
    wr_req = 1; wr_addr = 14'd1030; wr_data = 16'h07E0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hit_no_gnt", wr_gnt, 0);
      chk("hit_no_wen", ram_wr_en, 0);
    end
    step();
    pix_req = 0;
    step();
    @(negedge clk);
    chk("late_gnt", wr_gnt, 1);
    chk("late_wen", ram_wr_en, 1);
    chk("late_addr", ram_addr, 1030);
    step();
    wr_req = 0;
    read_px(300, 200, 1, 16'h07E0, "rd_300_200");

    do_write(14'd10000, 16'hBEEF, lat, wen_at, addr_at);
    chk("oor_wen", wen_at, 0);
    chk("oor_err", err_addr, 1);
    do_write(14'd5, 16'h001F, lat, wen_at, addr_at);
    chk("err_sticky", err_addr, 1);
    read_px(275, 190, 1, 16'h001F, "rd_275_190");

`ifdef FB_FRAME_LOCK_EN
    step();
    v_blank = 0;
    wr_req = 1; wr_addr = 14'd7; wr_data = 16'hABCD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lock_no_gnt", wr_gnt, 0);
    end
    step();
    v_blank = 1;
    step();
    @(negedge clk);
    chk("lock_gnt", wr_gnt, 1);
    step();
    wr_req = 0;
    read_px(277, 190, 1, 16'hABCD, "rd_locked_wr");
`endif

    // Reset landing in a grant cycle aborts the write
    step();
    wr_req = 1; wr_addr = 14'd8; wr_data = 16'h5555;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (wr_gnt) break;
      if (i == 60) begin
        checks++; errors++;
        $display("FAIL rst_wr_timeout act=nogrant exp=grant");
      end
    end
    chk("pre_rst_wen", ram_wr_en, 1);
    #5 rst_n = 0;
    #1;
    chk("rst_abort_wen", ram_wr_en, 0);
    chk("rst_abort_gnt", wr_gnt, 0);
    chk("rst_err_clr", err_addr, 0);
    wr_req = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    read_px(278, 190, 1, 16'h0000, "rd_aborted");
    read_px(270, 190, 1, 16'h0000, "rd_after_rst");
    chk("err_after_rst", err_addr, 0);

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Arbitrates one single-port 16-bit frame-buffer RAM between the VGA pixel read path and a pixel writer (e.g. UART/camera loader). Sits between the VGA controller's pixel coordinate/colour interface and the image RAM.
- Pixel reads inside the image window have absolute priority.
- Writes are granted only in free cycles.
- Pixels outside the window return a background colour.

Parameters:
IMG_W, 100, image width in pixels
IMG_H, 100, image height in pixels
IMG_X0, 270, window left edge (active-area X)
IMG_Y0, 190, window top edge (active-area Y)
ADDR_W, 14, RAM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
BG_COLOUR, 16'hFFFF, colour returned outside the window

Ports:
Clk_int  in  1  VGA pixel clock, 25 MHz
Sys_Rst_n  in  1  asynchronous reset, active-low
pix_req  in  1  colour request for (pix_x, pix_y), high during active area
pix_x  in  10  requested X coordinate
pix_y  in  10  requested Y coordinate
v_blank  in  1  high during vertical blanking
pix_colour  out  16  colour for the request issued 3 cycles earlier
wr_req  in  1  writer request; held with wr_addr/wr_data stable until wr_gnt
wr_addr  in  ADDR_W  write word address
wr_data  in  16  write pixel, RGB565
wr_gnt  out  1  one-cycle grant pulse; write performed this cycle
ram_addr  out  ADDR_W  RAM address
ram_wr_en  out  1  RAM write enable
ram_wr_data  out  16  RAM write data
ram_rd_data  in  16  RAM read data, 1-cycle registered-output latency
err_addr  out  1  sticky flag: a write with wr_addr >= IMG_W*IMG_H was seen

Behaviour:
- Reset:
  - Clocking: single clock Clk_int; Sys_Rst_n asynchronous, active-low.
  - Values: all outputs 0; FSM in S_IDLE; pipeline valid/in-window flags 0.
  - Mid-operation reset: a write in its grant cycle is aborted (ram_wr_en forced 0); the writer must re-request.
- Window hit: hit = pix_req & pix_x in [IMG_X0, IMG_X0+IMG_W-1] & pix_y in [IMG_Y0, IMG_Y0+IMG_H-1].
- Read address: (pix_y-IMG_Y0)*IMG_W + (pix_x-IMG_X0).
  - Computed at full width, truncated to ADDR_W.
  - Registered to ram_addr.
- FSM: S_IDLE, S_RD, S_WR. Evaluated each cycle t; the next state is visible in cycle t+1.
  - hit -> S_RD: ram_addr = read address, ram_wr_en = 0.
  - else if wr_req & !wr_gnt & wr_ok -> S_WR: ram_addr = wr_addr, ram_wr_data = wr_data, ram_wr_en = 1, wr_gnt = 1.
  - else -> S_IDLE: ram_wr_en = 0; ram_addr holds its value.
  - wr_ok = 1 by default (see Optional Feature).
- Simultaneous hit and wr_req: the read wins and the write waits; no fairness guarantee during the active window.
- wr_req is ignored in any cycle where wr_gnt = 1. The writer updates or drops its request in the cycle after the grant. Maximum write rate: 1 write per 2 cycles.
- Out-of-range write (wr_addr >= IMG_W*IMG_H):
  - It is granted (pulse issued) but ram_wr_en stays 0.
  - err_addr is set; cleared only by reset.
- Read pipeline, pix_req at cycle t:
  - t+1: ram_addr is valid.
  - t+2: ram_rd_data is valid.
  - t+3: registered pix_colour = ram_rd_data if the delayed hit = 1, else BG_COLOUR.
- No pix_req: pix_colour = 16'h0000 at t+3.
- Fixed latency of 3 regardless of write activity. The VGA controller must lead coordinates by 3 clocks.

Optional Feature:
Macro FB_FRAME_LOCK_EN.
- Defined: wr_ok = v_blank. Writes are granted only during vertical blanking, giving tear-free frame updates. Requests pend across active lines.
- Undefined: wr_ok = 1. Writes are granted in any non-hit cycle, including horizontal blanking and out-of-window pixels.

Decomposition:
- Package vga_fb_pkg:
  - H_VALID = 640, V_VALID = 480
  - RGB565 colour typedef
  - FSM state enum (S_IDLE, S_RD, S_WR)
  - default ADDR_W
  - BG colour constants (WHITE, BLACK)
- Sub-module vga_fb_addr_gen: combinational window check, read address, and the in-range check for wr_addr. Instantiated once, so the arbiter holds only the FSM and pipeline.

Test Plan:
- Reset released, pix_req = 0, wr_req = 0 -> all outputs 0; FSM S_IDLE for 10 cycles.
- Write wr_addr = 0, wr_data = 16'hF800 with no pix_req -> wr_gnt pulse 1 cycle later, ram_wr_en = 1, ram_addr = 0; then pix_req at (270,190) -> pix_colour = 16'hF800 exactly 3 cycles later.
- pix_req at (269,190) and (370,190) -> pix_colour = 16'hFFFF at t+3; no RAM read issued.
- pix_req at (300,200) concurrent with wr_req held -> ram_wr_en = 0 and wr_gnt = 0 while hit; grant in the first non-hit cycle; read data is correct.
- wr_addr = 10000 (IMG_W*IMG_H) -> wr_gnt = 1, ram_wr_en = 0, err_addr = 1 and stays 1 until Sys_Rst_n low.
- FB_FRAME_LOCK_EN defined, wr_req during active line with v_blank = 0 -> no grant; v_blank rises -> wr_gnt 1 cycle later. Assert Sys_Rst_n = 0 during a grant cycle -> ram_wr_en drops immediately.
